// File: rtl/decode_stage_mw_if.sv
// Bundle-level connection between fetch queue, decode stage and rename/dispatch.
// The slave modport is the decode stage; the master modport drives it and takes its results.
interface decode_stage_mw_if #(
  parameter int WAYS = 2,
  parameter int ADDR = 32,
  parameter int DATA = 32,
  parameter int INST = 32
);
  logic                   flush;
  logic                   inst_e_;
  logic [WAYS-1:0]        inst_mask;
  logic [ADDR-1:0]        inst_pc;
  logic [WAYS*INST-1:0]   inst;
  logic                   is_full;
  logic                   dec_busy;
  logic                   dec_e_out_;
  logic [WAYS-1:0]        lane_v_out;
  logic [WAYS*ADDR-1:0]   pc_out;
  logic [WAYS*6-1:0]      rs1_out;
  logic [WAYS*6-1:0]      rs2_out;
  logic [WAYS*6-1:0]      rd_out;
  logic [WAYS*DATA-1:0]   imm_out;
  logic [WAYS*3-1:0]      unit_out;
  logic [WAYS*3-1:0]      funct3_out;
  logic [WAYS-1:0]        alt_out;
  logic [WAYS-1:0]        invalid_out;

  modport master (
    output flush, inst_e_, inst_mask, inst_pc, inst, is_full,
    input  dec_busy, dec_e_out_, lane_v_out, pc_out, rs1_out, rs2_out, rd_out,
           imm_out, unit_out, funct3_out, alt_out, invalid_out
  );

  modport slave (
    input  flush, inst_e_, inst_mask, inst_pc, inst, is_full,
    output dec_busy, dec_e_out_, lane_v_out, pc_out, rs1_out, rs2_out, rd_out,
           imm_out, unit_out, funct3_out, alt_out, invalid_out
  );
endinterface

// File: rtl/decode_stage_mw.sv
// WAYS-wide RV32I decode stage: registered output bundle plus one skid entry,
// so the upstream stall (dec_busy) comes straight from a flop.
module decode_stage_mw #(
  parameter int WAYS = 2,
  parameter int ADDR = 32,
  parameter int DATA = 32,
  parameter int INST = 32
) (
  input logic              clk,
  input logic              reset,
  decode_stage_mw_if.slave bus
);
  localparam logic [2:0] UNIT_ALU    = 3'd0;
  localparam logic [2:0] UNIT_BRANCH = 3'd1;
  localparam logic [2:0] UNIT_JUMP   = 3'd2;
  localparam logic [2:0] UNIT_LOAD   = 3'd3;
  localparam logic [2:0] UNIT_STORE  = 3'd4;
  localparam logic [2:0] UNIT_NOP    = 3'd5;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef struct packed {
    logic            v;
    logic [ADDR-1:0] pc;
    logic [5:0]      rs1;
    logic [5:0]      rs2;
    logic [5:0]      rd;
    logic [DATA-1:0] imm;
    logic [2:0]      unit;
    logic [2:0]      funct3;
    logic            alt;
    logic            invalid;
  } lane_t;

  // Illegal encodings keep only valid/pc/invalid/unit so downstream sees no register use.
  function automatic lane_t decode_lane(input logic [INST-1:0] ins, input logic [ADDR-1:0] pc);
    lane_t      l;
    logic [31:0] imm32;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] unit;
    logic       use_rs1, use_rs2, use_rd, bad, alt;
    f3      = ins[14:12];
    f7      = ins[31:25];
    imm32   = '0;
    unit    = UNIT_ALU;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    bad     = 1'b0;
    alt     = 1'b0;
    l       = '0;
    l.v     = 1'b1;
    l.pc    = pc;
    case (ins[6:0])
      OPC_LUI, OPC_AUIPC: begin
        imm32  = {ins[31:12], 12'b0};
        use_rd = 1'b1;
        f3     = 3'd0;
        alt    = (ins[6:0] == OPC_AUIPC);
      end
      OPC_JAL: begin
        imm32  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        use_rd = 1'b1;
        unit   = UNIT_JUMP;
      end
      OPC_JALR: begin
        imm32   = {{20{ins[31]}}, ins[31:20]};
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        unit    = UNIT_JUMP;
      end
      OPC_BRANCH: begin
        imm32   = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        unit    = UNIT_BRANCH;
        bad     = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        imm32   = {{20{ins[31]}}, ins[31:20]};
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        unit    = UNIT_LOAD;
        bad     = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        imm32   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        unit    = UNIT_STORE;
        bad     = (f3 > 3'b010);
      end
      OPC_OP_IMM: begin
        imm32   = {{20{ins[31]}}, ins[31:20]};
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        if (f3 == 3'b001) begin
          bad = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          alt = ins[30];
        end
      end
      OPC_OP: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        alt     = ins[30];
        bad     = !((f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_MISC_MEM: unit = UNIT_NOP;
      default:      bad  = 1'b1;
    endcase
    if (bad) begin
      l.invalid = 1'b1;
      l.unit    = UNIT_NOP;
    end else begin
      l.rs1    = use_rs1 ? {1'b1, ins[19:15]} : 6'd0;
      l.rs2    = use_rs2 ? {1'b1, ins[24:20]} : 6'd0;
      l.rd     = (use_rd && (ins[11:7] != 5'd0)) ? {1'b1, ins[11:7]} : 6'd0;
      l.imm    = {{(DATA-31){imm32[31]}}, imm32[30:0]};
      l.unit   = unit;
      l.funct3 = f3;
      l.alt    = alt;
    end
    return l;
  endfunction

  lane_t [WAYS-1:0] dec_lane;
  lane_t [WAYS-1:0] out_q, out_d;
  lane_t [WAYS-1:0] skid_q, skid_d;
  logic             out_v_q, out_v_d;
  logic             skid_v_q, skid_v_d;
  logic             accept, in_v, xfer;

  assign accept = !bus.inst_e_ && !skid_v_q && !bus.flush;
  assign in_v   = accept && (|bus.inst_mask);
  assign xfer   = out_v_q && !bus.is_full;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_lane
    assign dec_lane[gi] = bus.inst_mask[gi]
                        ? decode_lane(bus.inst[gi*INST +: INST], bus.inst_pc + ADDR'(4 * gi))
                        : '0;
    assign bus.lane_v_out[gi]             = out_q[gi].v;
    assign bus.pc_out[gi*ADDR +: ADDR]    = out_q[gi].pc;
    assign bus.rs1_out[gi*6 +: 6]         = out_q[gi].rs1;
    assign bus.rs2_out[gi*6 +: 6]         = out_q[gi].rs2;
    assign bus.rd_out[gi*6 +: 6]          = out_q[gi].rd;
    assign bus.imm_out[gi*DATA +: DATA]   = out_q[gi].imm;
    assign bus.unit_out[gi*3 +: 3]        = out_q[gi].unit;
    assign bus.funct3_out[gi*3 +: 3]      = out_q[gi].funct3;
    assign bus.alt_out[gi]                = out_q[gi].alt;
    assign bus.invalid_out[gi]            = out_q[gi].invalid;
  end

  assign bus.dec_busy   = skid_v_q;
  assign bus.dec_e_out_ = !out_v_q;

  // The skid always drains ahead of the input, which keeps the stream in order.
  always_comb begin
    out_v_d  = out_v_q;
    out_d    = out_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (bus.flush) begin
      out_v_d  = 1'b0;
      out_d    = '0;
      skid_v_d = 1'b0;
      skid_d   = '0;
    end else if (!out_v_q || xfer) begin
      if (skid_v_q) begin
        out_v_d  = 1'b1;
        out_d    = skid_q;
        skid_v_d = 1'b0;
      end else if (in_v) begin
        out_v_d = 1'b1;
        out_d   = dec_lane;
      end else begin
        out_v_d = 1'b0;
        out_d   = '0;
      end
    end else if (in_v) begin
      skid_v_d = 1'b1;
      skid_d   = dec_lane;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v_q  <= 1'b0;
      out_q    <= '0;
      skid_v_q <= 1'b0;
      skid_q   <= '0;
    end else begin
      out_v_q  <= out_v_d;
      out_q    <= out_d;
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
    end
  end
endmodule
